// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: streams dot-product operand pairs into a DSP48A1-style slice and returns the accumulated P
module dsp_mac_sequencer #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START_VALID,
  output logic             START_READY,
  input  logic [LEN_W-1:0] LEN,
  input  logic             OP_VALID,
  output logic             OP_READY,
  input  logic [17:0]      OP_A,
  input  logic [17:0]      OP_B,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic             DSP_CEA,
  output logic             DSP_CEM,
  output logic             DSP_CEP,
  output logic [7:0]       DSP_OPMODE,
  input  logic [47:0]      DSP_P,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [47:0]      RES_DATA
);
  localparam int D = PIPE_LAT - 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [D-1:0]     pv_q, pv_d;
  logic [PIPE_LAT-1:0] tok_v;
  logic             op_first_q, op_first_d;
  logic [7:0]       opmode_q, opmode_d;
  logic [47:0]      res_q, res_d;
  logic             inj;
  assign DSP_A       = OP_A;
  assign DSP_B       = OP_B;
  assign START_READY = state_q == IDLE;
  assign OP_READY    = state_q == RUN && rem_q != '0;
  assign inj         = OP_VALID & OP_READY;
  assign DSP_CEA     = inj;
  assign DSP_CEM     = |tok_v[PIPE_LAT-1:1];
  assign DSP_CEP     = tok_v[PIPE_LAT-1];
  assign DSP_OPMODE  = opmode_d;
  assign RES_VALID   = state_q == DONE;
  assign RES_DATA    = res_q;
  // Token pipe: stage k is the token injected k cycles ago; OPMODE is chosen one cycle ahead of its CEP
  always_comb begin
    tok_v    = {pv_q, inj};
    pv_d     = tok_v[D-1:0];
    opmode_d = tok_v[PIPE_LAT-2] ? (op_first_q ? 8'h1E : 8'h16) : opmode_q;
  end
  // Job FSM: the first token reaching the OPMODE stage clears P, later ones accumulate
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    res_d      = res_q;
    op_first_d = tok_v[PIPE_LAT-2] ? 1'b0 : op_first_q;
    case (state_q)
      IDLE: if (START_VALID) begin
        state_d    = LEN != '0 ? RUN : DONE;
        rem_d      = LEN;
        op_first_d = LEN != '0;
        res_d      = '0;
      end
      RUN: if (inj) begin
        rem_d   = rem_q - 1'b1;
        state_d = rem_q == 1 ? DRAIN : RUN;
      end
      DRAIN: if (pv_q == '0) begin
        res_d   = DSP_P;
        state_d = DONE;
      end
      default: state_d = RES_READY ? IDLE : DONE;
    endcase
  end
  // State registers; reset aborts any job in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      pv_q       <= '0;
      op_first_q <= 1'b0;
      opmode_q   <= 8'h00;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      pv_q       <= pv_d;
      op_first_q <= op_first_d;
      opmode_q   <= opmode_d;
      res_q      <= res_d;
    end
  end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: scoreboard bench driving the sequencer into a behavioural slice model
module tb_dsp_mac_sequencer;
  localparam int PL = 3;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic start_valid = 1'b0, start_ready, op_valid = 1'b0, op_ready, res_valid, res_ready = 1'b0;
  logic [7:0] len = '0, dsp_opmode;
  logic [17:0] op_a = '0, op_b = '0, dsp_a, dsp_b;
  logic dsp_cea, dsp_cem, dsp_cep;
  logic [47:0] dsp_p, res_data;
  int total = 0, bad = 0, cyc = 0;
  logic [47:0] sb[$];
  logic [17:0] va[16], vb[16];
  dsp_mac_sequencer #(.LEN_W(8), .PIPE_LAT(PL)) dut (
    .CLK(clk), .RST(rst), .START_VALID(start_valid), .START_READY(start_ready), .LEN(len),
    .OP_VALID(op_valid), .OP_READY(op_ready), .OP_A(op_a), .OP_B(op_b),
    .DSP_A(dsp_a), .DSP_B(dsp_b), .DSP_CEA(dsp_cea), .DSP_CEM(dsp_cem), .DSP_CEP(dsp_cep),
    .DSP_OPMODE(dsp_opmode), .DSP_P(dsp_p), .RES_VALID(res_valid), .RES_READY(res_ready),
    .RES_DATA(res_data)
  );
  logic [17:0] a1 = '0, b1 = '0;
  logic [35:0] m = '0;
  logic [7:0] opm_r = '0;
  logic [47:0] p = '0;
  assign dsp_p = p;
  // Slice model: A1/B1 -> M -> P with registered OPMODE; 1E loads M, 16 adds M to P
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dsp_cea) begin
      a1 <= dsp_a;
      b1 <= dsp_b;
    end
    if (dsp_cem) m <= {18'b0, a1} * {18'b0, b1};
    opm_r <= dsp_opmode;
    if (dsp_cep) p <= {12'b0, m} + (opm_r == 8'h16 ? p : 48'h0);
  end
  int cep_n = 0, cea_n = 0, cem_n = 0;
  logic [7:0] opm_log[$];
  // Event monitor sampled mid-cycle
  always @(negedge clk) begin
    if (dsp_cep) begin
      cep_n <= cep_n + 1;
      opm_log.push_back(opm_r);
    end
    if (dsp_cea) cea_n <= cea_n + 1;
    if (dsp_cem) cem_n <= cem_n + 1;
  end
  function automatic logic [47:0] dot(input int n);
    logic [47:0] s = '0;
    for (int i = 0; i < n; i++) s = s + 48'(va[i]) * 48'(vb[i]);
    return s;
  endfunction
  task automatic start_job(input logic [7:0] n, output bit ok);
    int w = 0;
    ok = 1;
    while (!start_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!start_ready) begin ok = 0; return; end
    start_valid = 1; len = n;
    @(posedge clk); #1;
    start_valid = 0;
  endtask
  task automatic send_ops(input int n, input int gap, output int first_cyc, output bit ok);
    ok = 1; first_cyc = -1;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      int g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
      op_a = va[i]; op_b = vb[i]; op_valid = 1;
      while (!op_ready && w < 50) begin @(posedge clk); #1; w++; end
      if (!op_ready) begin ok = 0; op_valid = 0; return; end
      @(posedge clk); #1;
      if (i == 0) first_cyc = cyc;
      op_valid = 0;
      for (int k = 0; k < g; k++) begin @(posedge clk); #1; end
    end
  endtask
  task automatic get_result(output logic [47:0] d, output int vcyc, output bit ok);
    int w = 0;
    ok = 1; d = '0; vcyc = cyc;
    while (!res_valid && w < 100) begin @(posedge clk); #1; w++; end
    if (!res_valid) begin ok = 0; return; end
    vcyc = cyc; d = res_data;
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask
  task automatic test_reset();
    rst = 1; #1;
    total++;
    if ({start_ready, op_ready, dsp_cea, dsp_cem, dsp_cep, res_valid} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 100000", {start_ready, op_ready, dsp_cea, dsp_cem, dsp_cep, res_valid});
    end
    total++;
    if (dsp_opmode !== 8'h00 || res_data !== 48'h0) begin
      bad++; $display("FAIL reset_data: got opmode=%h res=%h want 00/0", dsp_opmode, res_data);
    end
    repeat (2) @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic test_basic();
    bit ok; int fc, vc, c0, o0; logic [47:0] d, e; logic [23:0] seq;
    va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = 6; vb[2] = 7;
    sb.push_back(dot(3)); c0 = cep_n; o0 = opm_log.size();
    start_job(3, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_start: got timeout want accept"); end
    send_ops(3, 0, fc, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_ops: got timeout want accept"); end
    total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL basic_drain_ready: got %b want 0", op_ready); end
    get_result(d, vc, ok);
    e = sb.pop_front();
    total++; if (!ok || d !== e) begin bad++; $display("FAIL basic_data: got %0d want %0d", d, e); end
    total++; if (vc - fc !== 3 + PL - 1) begin bad++; $display("FAIL basic_latency: got %0d want %0d", vc - fc, 3 + PL - 1); end
    total++; if (cep_n - c0 !== 3) begin bad++; $display("FAIL basic_cep: got %0d want 3", cep_n - c0); end
    seq = {opm_log[o0], opm_log[o0+1], opm_log[o0+2]};
    total++; if (seq !== 24'h1E1616) begin bad++; $display("FAIL basic_opmode: got %h want 1e1616", seq); end
    total++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin bad++; $display("FAIL basic_idle: got v=%b sr=%b want 0/1", res_valid, start_ready); end
  endtask
  task automatic test_max();
    bit ok; int fc, vc; logic [47:0] d, e;
    va[0] = 18'h3FFFF; vb[0] = 18'h3FFFF;
    sb.push_back(dot(1));
    start_job(1, ok);
    send_ops(1, 0, fc, ok);
    get_result(d, vc, ok);
    e = sb.pop_front();
    total++; if (!ok || d !== e || d !== 48'h000FFFF80001) begin bad++; $display("FAIL max_data: got %h want %h", d, e); end
    total++; if (vc - fc !== PL) begin bad++; $display("FAIL max_latency: got %0d want %0d", vc - fc, PL); end
  endtask
  task automatic test_stall();
    bit ok; int fc, vc, c0; logic [47:0] d, e;
    for (int i = 0; i < 4; i++) begin va[i] = 18'(i + 1); vb[i] = 18'(i + 1); end
    sb.push_back(dot(4)); c0 = cep_n;
    start_job(4, ok);
    send_ops(4, 2, fc, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_ops: got timeout want accept"); end
    get_result(d, vc, ok);
    e = sb.pop_front();
    total++; if (!ok || d !== e) begin bad++; $display("FAIL stall_data: got %0d want %0d", d, e); end
    total++; if (cep_n - c0 !== 4) begin bad++; $display("FAIL stall_cep: got %0d want 4", cep_n - c0); end
  endtask
  task automatic test_zero();
    bit ok; int s, vc, a0, m0, c0; logic [47:0] d, e;
    sb.push_back(dot(0)); a0 = cea_n; m0 = cem_n; c0 = cep_n;
    start_job(0, ok);
    s = cyc;
    get_result(d, vc, ok);
    e = sb.pop_front();
    total++; if (!ok || d !== e) begin bad++; $display("FAIL zero_data: got %h want %h", d, e); end
    total++; if (vc - s > 1) begin bad++; $display("FAIL zero_latency: got %0d want <=1", vc - s); end
    total++; if (cea_n != a0 || cem_n != m0 || cep_n != c0) begin
      bad++; $display("FAIL zero_enables: got cea=%0d cem=%0d cep=%0d want 0", cea_n - a0, cem_n - m0, cep_n - c0);
    end
  endtask
  task automatic test_backpressure();
    bit ok; int fc, w = 0; logic [47:0] e;
    va[0] = 3; vb[0] = 4; va[1] = 5; vb[1] = 6;
    sb.push_back(dot(2));
    start_job(2, ok);
    send_ops(2, 0, fc, ok);
    while (!res_valid && w < 100) begin @(posedge clk); #1; w++; end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (res_valid !== 1'b1 || res_data !== e || start_ready !== 1'b0) begin
        bad++; $display("FAIL hold_%0d: got v=%b d=%0d sr=%b want 1/%0d/0", k, res_valid, res_data, start_ready, e);
      end
      @(posedge clk); #1;
    end
    res_ready = 1;
    total++; if (start_ready !== 1'b0) begin bad++; $display("FAIL accept_cycle_ready: got %b want 0", start_ready); end
    @(posedge clk); #1;
    res_ready = 0;
    total++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL after_accept: got sr=%b v=%b want 1/0", start_ready, res_valid); end
  endtask
  task automatic test_abort();
    bit ok; int fc, vc; logic [47:0] d, e;
    for (int i = 0; i < 8; i++) begin va[i] = 18'(100 + i); vb[i] = 18'(200 + i); end
    start_job(8, ok);
    send_ops(3, 0, fc, ok);
    #2 rst = 1;
    #1;
    total++;
    if ({start_ready, op_ready, dsp_cem, dsp_cep, res_valid} !== 5'b10000 || dsp_opmode !== 8'h00 || res_data !== 48'h0) begin
      bad++; $display("FAIL abort_reset: got ctrl=%b opmode=%h res=%h want 10000/00/0", {start_ready, op_ready, dsp_cem, dsp_cep, res_valid}, dsp_opmode, res_data);
    end
    @(posedge clk); #1;
    rst = 0;
    va[0] = 5; vb[0] = 5; va[1] = 1; vb[1] = 1;
    sb.push_back(dot(2));
    start_job(2, ok);
    send_ops(2, 0, fc, ok);
    get_result(d, vc, ok);
    e = sb.pop_front();
    total++; if (!ok || d !== e || d !== 48'd26) begin bad++; $display("FAIL abort_next: got %0d want %0d", d, e); end
  endtask
  task automatic test_back_to_back();
    bit ok; int fc, vc, n; logic [47:0] d, e;
    for (int j = 0; j < 5; j++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin va[i] = 18'($urandom); vb[i] = 18'($urandom); end
      sb.push_back(dot(n));
      start_job(8'(n), ok);
      send_ops(n, -1, fc, ok);
      get_result(d, vc, ok);
      e = sb.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL b2b_%0d: got %h want %h", j, d, e); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_max();
    test_stall();
    test_zero();
    test_backpressure();
    test_abort();
    test_back_to_back();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_empty: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
